// File: rtl/bcd_seq_ctrl.sv
// Cascaded BCD event counter with prescaler, limit detection and run/pause control.
// Optional lap-capture register is built only when BCD_SEQ_LAP_EN is defined.
module bcd_seq_ctrl #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic [4*DIGITS-1:0]   limit_val,
  output logic [4*DIGITS-1:0]   count,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  running,
  output logic                  done,
  output logic                  ovf,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   lap_count
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TickMax = PW'(TICK_DIV - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StPause = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [W-1:0]      count_q, count_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [DIGITS-1:0] digit_en_q, digit_en_d;
  logic              ovf_q, ovf_d;

  logic              tick;
  logic              carry;
  logic              wrap;
  logic [3:0]        digit;
  logic [3:0]        ld_digit;
  logic [W-1:0]      inc_val;
  logic [DIGITS-1:0] inc_en;
  logic [W-1:0]      load_clean;

  // Ripple-carry BCD increment: a digit advances only when every lower digit is 9.
  always_comb begin
    carry      = 1'b1;
    digit      = 4'd0;
    ld_digit   = 4'd0;
    inc_val    = count_q;
    inc_en     = '0;
    load_clean = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      digit     = count_q[4*i +: 4];
      inc_en[i] = carry;
      if (carry) begin
        inc_val[4*i +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
      end
      carry = carry & (digit == 4'd9);
      ld_digit = load_val[4*i +: 4];
      load_clean[4*i +: 4] = (ld_digit > 4'd9) ? 4'd0 : ld_digit;
    end
    wrap = carry;
  end

  assign tick = (state_q == StRun) && (presc_q == TickMax);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    presc_d    = presc_q;
    digit_en_d = '0;
    ovf_d      = 1'b0;
    if (clear) begin
      state_d = StIdle;
      count_d = '0;
      presc_d = '0;
    end else if (load) begin
      state_d = StIdle;
      count_d = load_clean;
      presc_d = '0;
    end else begin
      if (state_q == StRun) begin
        presc_d = tick ? '0 : presc_q + 1'b1;
      end
      if (stop) begin
        if (state_q == StRun) state_d = StPause;
      end else if (start && (state_q == StIdle || state_q == StPause)) begin
        state_d = StRun;
      end
      // Reaching the limit takes precedence over a coincident stop.
      if (tick) begin
        count_d    = inc_val;
        digit_en_d = inc_en;
        ovf_d      = wrap;
        if (inc_val == limit_val) state_d = StDone;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      presc_q    <= '0;
      digit_en_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      presc_q    <= presc_d;
      digit_en_q <= digit_en_d;
      ovf_q      <= ovf_d;
    end
  end

  assign count    = count_q;
  assign digit_en = digit_en_q;
  assign ovf      = ovf_q;
  assign running  = (state_q == StRun);
  assign done     = (state_q == StDone);

`ifdef BCD_SEQ_LAP_EN
  logic [W-1:0] lap_q;

  // Captures the pre-update count, so a coincident tick is not seen here.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      lap_q <= '0;
    end else if (clear) begin
      lap_q <= '0;
    end else if (lap && (state_q == StRun || state_q == StPause)) begin
      lap_q <= count_q;
    end
  end

  assign lap_count = lap_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_count  = '0;
`endif

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Scoreboard bench for bcd_seq_ctrl: decimal-arithmetic reference model, directed
// scenarios followed by randomized commands.
module tb_bcd_seq_ctrl;

  localparam int DIGITS = 4;
  localparam int TD     = 10;
  localparam int MOD    = 10000;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, clear, load, lap;
  logic [15:0] load_val, limit_val;
  logic [15:0] count, lap_count;
  logic [3:0]  digit_en;
  logic        running, done, ovf;

  bcd_seq_ctrl #(.DIGITS(DIGITS), .TICK_DIV(TD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .load      (load),
    .load_val  (load_val),
    .limit_val (limit_val),
    .count     (count),
    .digit_en  (digit_en),
    .running   (running),
    .done      (done),
    .ovf       (ovf),
    .lap       (lap),
    .lap_count (lap_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] cnt;
    logic [3:0]  en;
    logic        run;
    logic        dn;
    logic        ov;
    logic [15:0] lp;
  } obs_t;

  obs_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state: 0 idle, 1 run, 2 pause, 3 done; count kept as a decimal integer.
  int          m_state = 0;
  int          m_cnt   = 0;
  int          m_presc = 0;
  logic [15:0] m_lap   = '0;

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int from_load(logic [15:0] lv);
    int v, p;
    logic [3:0] d;
    v = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = lv[4*i +: 4];
      v = v + ((d > 9) ? 0 : int'(d)) * p;
      p = p * 10;
    end
    return v;
  endfunction

  task automatic model_step();
    obs_t        e;
    logic [15:0] ob, nb;
    int          nxt;
    bit          tk;
    e.en = '0;
    e.ov = 1'b0;
    if (rst_n) begin
      m_state = 0;
      m_cnt   = 0;
      m_presc = 0;
      m_lap   = '0;
    end else begin
      tk = (m_state == 1) && (m_presc == TD - 1);
`ifdef BCD_SEQ_LAP_EN
      if (lap && (m_state == 1 || m_state == 2)) m_lap = to_bcd(m_cnt);
      if (clear) m_lap = '0;
`endif
      if (clear) begin
        m_state = 0; m_cnt = 0; m_presc = 0;
      end else if (load) begin
        m_state = 0; m_cnt = from_load(load_val); m_presc = 0;
      end else begin
        if (m_state == 1) m_presc = tk ? 0 : m_presc + 1;
        if (stop) begin
          if (m_state == 1) m_state = 2;
        end else if (start && (m_state == 0 || m_state == 2)) begin
          m_state = 1;
        end
        if (tk) begin
          nxt = (m_cnt + 1) % MOD;
          ob  = to_bcd(m_cnt);
          nb  = to_bcd(nxt);
          for (int i = 0; i < DIGITS; i++) e.en[i] = (ob[4*i +: 4] != nb[4*i +: 4]);
          e.ov  = (m_cnt == MOD - 1);
          m_cnt = nxt;
          if (nb == limit_val) m_state = 3;
        end
      end
    end
    e.cnt = to_bcd(m_cnt);
    e.run = (m_state == 1);
    e.dn  = (m_state == 3);
    e.lp  = m_lap;
    sb.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #2;
    end
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    obs_t e, g;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      g = '{cnt: count, en: digit_en, run: running, dn: done, ov: ovf, lp: lap_count};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: got cnt=%h en=%b run=%b done=%b ovf=%b lap=%h, expected cnt=%h en=%b run=%b done=%b ovf=%b lap=%h",
                 $time, g.cnt, g.en, g.run, g.dn, g.ov, g.lp, e.cnt, e.en, e.run, e.dn, e.ov, e.lp);
      end
    end
  end

  initial begin
    rst_n = 1'b1; start = 0; stop = 0; clear = 0; load = 0; lap = 0;
    load_val = '0; limit_val = 16'hFFFF;
    step(2);
    rst_n = 1'b0;
    step(1);
    check("reset_count", 32'(count), 32'h0);
    check("reset_running", 32'(running), 32'h0);

    // Free-running count from zero.
    start = 1; step(1); start = 0;
    step(9);  check("cnt_before_tick", 32'(count), 32'h0000);
    step(1);  check("cnt_first_tick", 32'(count), 32'h0001);
    step(89); check("cnt_0009", 32'(count), 32'h0009);
    step(1);  check("cnt_0010", 32'(count), 32'h0010);
    check("digit_en_0011", 32'(digit_en), 32'h3);

    // Pause keeps count and prescaler.
    clear = 1; step(1); clear = 0;
    start = 1; step(1); start = 0;
    step(24);
    stop = 1; step(1); stop = 0;
    step(50); check("pause_hold", 32'(count), 32'h0002);
    check("pause_not_running", 32'(running), 32'h0);
    start = 1; step(1); start = 0;
    step(4);  check("resume_pre_tick", 32'(count), 32'h0002);
    step(1);  check("resume_tick", 32'(count), 32'h0003);

    // Load sanitising and start+stop in idle.
    load_val = 16'h12AF; load = 1; step(1); load = 0;
    check("load_sanitise", 32'(count), 32'h1200);
    start = 1; stop = 1; step(1); start = 0; stop = 0;
    check("start_stop_idle", 32'(running), 32'h0);

    // Wrap with overflow, then limit stop.
    load_val = 16'h9999; limit_val = 16'h0500; load = 1; step(1); load = 0;
    start = 1; step(1); start = 0;
    step(9);  check("pre_wrap", 32'(count), 32'h9999);
    step(1);  check("wrap_cnt", 32'(count), 32'h0000);
    check("wrap_ovf", 32'(ovf), 32'h1);
    check("wrap_running", 32'(running), 32'h1);
    step(1);  check("ovf_one_cycle", 32'(ovf), 32'h0);
    step(4999);
    check("limit_done", 32'(done), 32'h1);
    check("limit_cnt", 32'(count), 32'h0500);
    start = 1; step(30); start = 0;
    check("done_hold", 32'(count), 32'h0500);
    check("done_ignores_start", 32'(done), 32'h1);

    // Reset in DONE, then clear coinciding with a wrap tick.
    rst_n = 1; step(1); rst_n = 0;
    check("rst_in_done_cnt", 32'(count), 32'h0);
    check("rst_in_done_done", 32'(done), 32'h0);
    limit_val = 16'hFFFF;
    load_val = 16'h9999; load = 1; step(1); load = 0;
    start = 1; step(1); start = 0;
    step(9);
    clear = 1; step(1); clear = 0;
    check("clear_tick_cnt", 32'(count), 32'h0);
    check("clear_tick_ovf", 32'(ovf), 32'h0);
    check("clear_tick_en", 32'(digit_en), 32'h0);

    // Lap capture.
    load_val = 16'h0035; load = 1; step(1); load = 0;
    start = 1; step(1); start = 0;
    step(20);
    lap = 1; step(1); lap = 0;
    step(15);
    check("lap_cnt_continues", 32'(count), 32'h0038);
`ifdef BCD_SEQ_LAP_EN
    check("lap_value", 32'(lap_count), 32'h0037);
`else
    check("lap_value", 32'(lap_count), 32'h0000);
`endif

    // Randomized commands.
    for (int i = 0; i < 6000; i++) begin
      rst_n = ($urandom_range(0, 399) == 0);
      clear = ($urandom_range(0, 99) == 0);
      load  = ($urandom_range(0, 59) == 0);
      if (load) begin
        case ($urandom_range(0, 2))
          0:       load_val = 16'($urandom);
          1:       load_val = 16'h9990 | 16'($urandom_range(0, 15));
          default: load_val = to_bcd($urandom_range(0, MOD - 1));
        endcase
      end
      if ($urandom_range(0, 149) == 0) begin
        case ($urandom_range(0, 2))
          0:       limit_val = to_bcd((m_cnt + $urandom_range(1, 20)) % MOD);
          1:       limit_val = 16'h0000;
          default: limit_val = 16'hFFFF;
        endcase
      end
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      lap   = ($urandom_range(0, 9) == 0);
      step(1);
    end
    rst_n = 0; start = 0; stop = 0; clear = 0; load = 0; lap = 0;
    step(2);
    #10;
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_seq_ctrl.md
BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

Interface
REQ-001 Parameter DIGITS, default 4: number of cascaded BCD digits, legal range 1..8.
REQ-002 Parameter TICK_DIV, default 10: clk cycles per count tick, legal range 1..1023.
REQ-003 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  in  1  reset; synchronous, active-high despite the name.
REQ-005 Port start  in  1  level command: begin or resume counting.
REQ-006 Port stop  in  1  level command: pause counting.
REQ-007 Port clear  in  1  level command: zero count and prescaler, enter IDLE.
REQ-008 Port load  in  1  level command: copy load_val into count, enter IDLE.
REQ-009 Port load_val  in  4*DIGITS  preset value, digit 0 in bits [3:0].
REQ-010 Port limit_val  in  4*DIGITS  terminal count; sampled every tick.
REQ-011 Port count  out  4*DIGITS  current BCD count, registered.
REQ-012 Port digit_en  out  DIGITS  registered; bit i high on cycles where digit i advanced.
REQ-013 Port running  out  1  high while state is RUN.
REQ-014 Port done  out  1  high while state is DONE.
REQ-015 Port ovf  out  1  one-cycle pulse on 99..9 -> 00..0 wrap.
REQ-016 Port lap  in  1  capture strobe (see Configuration).
REQ-017 Port lap_count  out  4*DIGITS  captured count (see Configuration).

Function
REQ-018 The FSM SHALL have states IDLE, RUN, PAUSE and DONE.
REQ-019 Command priority SHALL be clear > load > stop > start, with one command acted on per cycle.
REQ-020 Transitions: IDLE/PAUSE + start -> RUN; RUN + stop -> PAUSE; any + clear -> IDLE with count=0; any + load -> IDLE with count=load_val; DONE ignores start and stop.
REQ-021 On load, any load_val digit above 9 SHALL be stored as 0.
REQ-022 The prescaler SHALL advance only in RUN, issue a tick when it reaches TICK_DIV-1, then return to 0; it holds its value in PAUSE, and clear, load and rst_n zero it.
REQ-023 On a tick, digit 0 SHALL increment, and digit i>0 SHALL increment only when all lower digits equal 9.
REQ-024 Any digit that increments from 9 SHALL wrap to 0.
REQ-025 count SHALL update on the clk edge after the tick cycle, with one-cycle latency from tick to count.
REQ-026 If the post-increment count equals limit_val, the FSM SHALL enter DONE in the same edge, and count SHALL hold that value.
REQ-027 If count is all 9s and limit is not hit, a tick SHALL wrap count to all 0s, pulse ovf for one cycle, and leave the FSM in RUN.
REQ-028 If limit_val equals the current count on entry to RUN, no DONE SHALL occur until the count wraps back around to that value.
REQ-029 If start and stop are asserted together, stop SHALL win.
REQ-030 If clear or load coincides with a tick, the tick SHALL be discarded, with no ovf and no digit_en.

Reset
REQ-031 With rst_n high at a clk edge, the block SHALL go to state IDLE and set count=0, prescaler=0, digit_en=0, running=0, done=0, ovf=0 and lap_count=0.
REQ-032 Reset SHALL override all commands, including mid-count and in DONE.

Configuration
REQ-033 Macro BCD_SEQ_LAP_EN SHALL control the lap-capture feature.
REQ-034 With BCD_SEQ_LAP_EN defined, a lap high in RUN or PAUSE SHALL register count into lap_count on the next edge, and lap_count SHALL hold until the next capture, clear or reset.
REQ-035 With BCD_SEQ_LAP_EN defined, when lap coincides with a count update, lap_count SHALL take the pre-update value.
REQ-036 With BCD_SEQ_LAP_EN undefined, lap SHALL be ignored, lap_count SHALL be constant 0, and no capture register SHALL exist.

Verification
REQ-037 DIGITS=4, TICK_DIV=10, start held 1 cycle -> count=0001 after 10 clk and 0010 after 100 clk, with digit_en=0011 on the 0009->0010 update.
REQ-038 Load 9999, limit 0500, start -> next tick gives count=0000, ovf for 1 cycle, running=1; at count 0500 -> done=1, count holds 0500.
REQ-039 Start, then stop after 25 clk, wait 50 clk, then start -> count stays 0002 during pause, and the next tick comes 5 clk after resume.
REQ-040 Load with load_val=0x12AF -> count=1200; simultaneous start+stop in IDLE -> stays IDLE.
REQ-041 rst_n pulsed in DONE with count=0500 -> count=0000, IDLE; clear coincident with a tick -> count=0000, no ovf.
REQ-042 With BCD_SEQ_LAP_EN: lap at count 0037 -> lap_count=0037 while count continues; without the macro -> lap_count stays 0000.
